// File: rtl/bsg_cache_prefetch_buffer.sv
// rtl/bsg_cache_prefetch_buffer.sv - prefetch line buffer with in-order DMA issue and consuming probe lookup
module bsg_cache_prefetch_buffer #(
   parameter int addr_width_p         = 32,
   parameter int data_width_p         = 32,
   parameter int entries_p            = 4,
   parameter int block_offset_width_p = 6
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [addr_width_p-1:0] pf_addr_i,
   input  logic                    pf_v_i,
   output logic                    pf_ready_o,
   output logic [addr_width_p-1:0] dma_addr_o,
   output logic                    dma_v_o,
   input  logic                    dma_yumi_i,
   input  logic [data_width_p-1:0] dma_data_i,
   input  logic                    dma_data_v_i,
   input  logic                    lookup_v_i,
   input  logic [addr_width_p-1:0] lookup_addr_i,
   output logic                    lookup_hit_o,
   output logic [data_width_p-1:0] lookup_data_o,
   input  logic                    flush_i
);

   localparam int lg_entries_lp = $clog2(entries_p);
   localparam logic [addr_width_p-1:0] line_mask_lp = {addr_width_p{1'b1}} << block_offset_width_p;

   typedef logic [lg_entries_lp-1:0] idx_t;
   typedef enum logic [1:0] {E_INVALID, E_PENDING, E_ISSUED, E_VALID} entry_state_e;

   entry_state_e            st_q   [entries_p];
   entry_state_e            st_d   [entries_p];
   logic [addr_width_p-1:0] tag_q  [entries_p];
   logic [addr_width_p-1:0] tag_d  [entries_p];
   logic [data_width_p-1:0] data_q [entries_p];
   logic [data_width_p-1:0] data_d [entries_p];
   logic                    disc_q [entries_p];
   logic                    disc_d [entries_p];
   idx_t                    ring_q [entries_p];
   idx_t                    ring_d [entries_p];
   idx_t                    tail_q, tail_d, issue_q, issue_d, resp_q, resp_d;
   logic                    lookup_hit_q, lookup_hit_d;
   logic [data_width_p-1:0] lookup_data_q, lookup_data_d;

   logic [addr_width_p-1:0] pf_line, lookup_line;
   idx_t                    head_idx, resp_idx, free_idx, hit_idx;
   logic                    dup, hit, yumi_v, resp_v, accept, keep_head;

   assign pf_line     = pf_addr_i & line_mask_lp;
   assign lookup_line = lookup_addr_i & line_mask_lp;
   assign head_idx    = ring_q[issue_q];
   assign resp_idx    = ring_q[resp_q];

   // issue==tail is ambiguous between empty and all-pending; the head state resolves it
   assign dma_v_o    = (issue_q != tail_q) || (st_q[head_idx] == E_PENDING);
   assign dma_addr_o = tag_q[head_idx];
   assign yumi_v     = dma_yumi_i && dma_v_o;
   assign resp_v     = dma_data_v_i && (st_q[resp_idx] == E_ISSUED);
   assign accept     = pf_v_i && pf_ready_o && !flush_i && !dup;
   assign keep_head  = flush_i && dma_v_o;

   assign lookup_hit_o  = lookup_hit_q;
   assign lookup_data_o = lookup_data_q;

   // scan entries: lowest free slot, duplicate detection, lowest valid probe match
   always_comb begin
      pf_ready_o = 1'b0;
      free_idx   = '0;
      dup        = 1'b0;
      hit        = 1'b0;
      hit_idx    = '0;
      for (int i = entries_p - 1; i >= 0; i--) begin
         if (st_q[i] == E_INVALID) begin
            pf_ready_o = 1'b1;
            free_idx   = idx_t'(i);
         end else if (tag_q[i] == pf_line) begin
            dup = 1'b1;
         end
         if ((st_q[i] == E_VALID) && (tag_q[i] == lookup_line)) begin
            hit     = 1'b1;
            hit_idx = idx_t'(i);
         end
      end
   end

   // next-state: flush first, then yumi, response, lookup and allocation on distinct entries
   always_comb begin
      st_d          = st_q;
      tag_d         = tag_q;
      data_d        = data_q;
      disc_d        = disc_q;
      ring_d        = ring_q;
      tail_d        = tail_q;
      issue_d       = issue_q;
      resp_d        = resp_q;
      lookup_hit_d  = 1'b0;
      lookup_data_d = lookup_data_q;

      if (flush_i) begin
         for (int i = 0; i < entries_p; i++) begin
            if (st_q[i] == E_VALID) begin
               st_d[i] = E_INVALID;
            end else if (st_q[i] == E_ISSUED) begin
               disc_d[i] = 1'b1;
            end else if ((st_q[i] == E_PENDING) && !(keep_head && (idx_t'(i) == head_idx))) begin
               st_d[i] = E_INVALID;
            end
         end
         tail_d = keep_head ? issue_q + idx_t'(1) : issue_q;
      end

      if (yumi_v) begin
         st_d[head_idx]   = E_ISSUED;
         disc_d[head_idx] = flush_i;
         issue_d          = issue_q + idx_t'(1);
      end

      if (resp_v) begin
         data_d[resp_idx] = dma_data_i;
         st_d[resp_idx]   = (disc_q[resp_idx] || flush_i) ? E_INVALID : E_VALID;
         disc_d[resp_idx] = 1'b0;
         resp_d           = resp_q + idx_t'(1);
      end

      if (lookup_v_i && hit && !flush_i) begin
         lookup_hit_d    = 1'b1;
         lookup_data_d   = data_q[hit_idx];
         st_d[hit_idx]   = E_INVALID;
      end

      if (accept) begin
         st_d[free_idx]   = E_PENDING;
         tag_d[free_idx]  = pf_line;
         disc_d[free_idx] = 1'b0;
         ring_d[tail_q]   = free_idx;
         tail_d           = tail_q + idx_t'(1);
      end
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < entries_p; i++) begin
            st_q[i]   <= E_INVALID;
            tag_q[i]  <= '0;
            data_q[i] <= '0;
            disc_q[i] <= 1'b0;
            ring_q[i] <= '0;
         end
         tail_q        <= '0;
         issue_q       <= '0;
         resp_q        <= '0;
         lookup_hit_q  <= 1'b0;
         lookup_data_q <= '0;
      end else begin
         st_q          <= st_d;
         tag_q         <= tag_d;
         data_q        <= data_d;
         disc_q        <= disc_d;
         ring_q        <= ring_d;
         tail_q        <= tail_d;
         issue_q       <= issue_d;
         resp_q        <= resp_d;
         lookup_hit_q  <= lookup_hit_d;
         lookup_data_q <= lookup_data_d;
      end
   end

endmodule
